// File: rtl/brief_pkg.sv
// Shared types and packed keypoint layout for the BRIEF keypoint scheduler.
package brief_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_WORK = 2'd2
  } state_t;

  localparam int unsigned COOR_W  = 10;
  localparam int unsigned TRIG_W  = 12;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned KP_W    = 2 * COOR_W + 2 * TRIG_W + SCORE_W;

  // y sits directly above x so the slice {y,x} is the raster-order key
  localparam int unsigned KP_SCORE_LSB = 0;
  localparam int unsigned KP_COS_LSB   = KP_SCORE_LSB + SCORE_W;
  localparam int unsigned KP_SIN_LSB   = KP_COS_LSB + TRIG_W;
  localparam int unsigned KP_X_LSB     = KP_SIN_LSB + TRIG_W;
  localparam int unsigned KP_Y_LSB     = KP_X_LSB + COOR_W;

  function automatic logic [KP_W-1:0] kp_pack(
    input logic [COOR_W-1:0]  x,
    input logic [COOR_W-1:0]  y,
    input logic [TRIG_W-1:0]  s,
    input logic [TRIG_W-1:0]  c,
    input logic [SCORE_W-1:0] score
  );
    return {y, x, s, c, score};
  endfunction

endpackage

// File: rtl/brief_kp_fifo.sv
// Synchronous keypoint FIFO with flush; a push in the flush cycle becomes the sole entry.
module brief_kp_fifo
  import brief_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned W     = KP_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_head,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= {{(AW-1){1'b0}}, i_push};
      cnt    <= {{AW{1'b0}}, i_push};
    end else begin
      if (i_push) wr_ptr <= wr_ptr + 1'b1;
      if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (i_push && !i_pop)      cnt <= cnt + 1'b1;
      else if (i_pop && !i_push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) mem[i_flush ? '0 : wr_ptr] <= i_data;
  end

  always_comb begin
    o_head  = mem[rd_ptr];
    o_level = cnt;
    o_full  = (cnt == (AW+1)'(DEPTH));
    o_empty = (cnt == '0);
  end

endmodule

// File: rtl/brief_kp_scheduler.sv
// Frame sequencer and keypoint scheduler feeding the BRIEF unit.
// Optional BRIEF_DROP_CNT_EN adds o_drop_cnt (stale pops + full drops, saturating).
module brief_kp_scheduler
  import brief_pkg::*;
#(
  parameter int unsigned WIDTH    = 640,
  parameter int unsigned HEIGHT   = 480,
  parameter int unsigned FILL_LAT = 9612,
  parameter int unsigned DEPTH    = 128
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_flag,
  input  logic [COOR_W-1:0]      i_coor_x,
  input  logic [COOR_W-1:0]      i_coor_y,
  input  logic [TRIG_W-1:0]      i_sin,
  input  logic [TRIG_W-1:0]      i_cos,
  input  logic [SCORE_W-1:0]     i_score,
  output logic                   o_start,
  output logic                   o_end,
  output logic                   o_win_vld,
  output logic [COOR_W-1:0]      o_cx,
  output logic [COOR_W-1:0]      o_cy,
  output logic                   o_hit,
  output logic [COOR_W-1:0]      o_kp_x,
  output logic [COOR_W-1:0]      o_kp_y,
  output logic [TRIG_W-1:0]      o_sin,
  output logic [TRIG_W-1:0]      o_cos,
  output logic [SCORE_W-1:0]     o_score,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full
`ifdef BRIEF_DROP_CNT_EN
  , output logic [15:0]          o_drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(FILL_LAT + 1);
  // FILL lasts FILL_LAT-1 cycles so centre (0,0) lands FILL_LAT cycles after i_start
  localparam logic [CW-1:0]     FILL_END = CW'(FILL_LAT - 2);
  localparam logic [COOR_W-1:0] CX_LAST  = COOR_W'(WIDTH - 1);
  localparam logic [COOR_W-1:0] CY_LAST  = COOR_W'(HEIGHT - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [COOR_W-1:0]   cx, cy;
  logic                win_vld, end_q;

  logic [KP_W-1:0]     head;
  logic                empty, full;
  logic [2*COOR_W-1:0] key_h, key_c;
  logic                head_ok, hit, pop, push, flush, frame_last;

  always_comb begin
    key_h      = head[KP_X_LSB +: 2*COOR_W];
    key_c      = {cy, cx};
    head_ok    = (state == S_WORK) && !empty;
    hit        = head_ok && (key_h == key_c);
    pop        = head_ok && (key_h <= key_c);
    frame_last = (state == S_WORK) && (cx == CX_LAST) && (cy == CY_LAST);
    flush      = i_start || frame_last;
    push       = i_flag && (!full || pop || flush);
  end

  brief_kp_fifo #(.DEPTH(DEPTH), .W(KP_W)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (flush),
    .i_data  (kp_pack(i_coor_x, i_coor_y, i_sin, i_cos, i_score)),
    .o_head  (head),
    .o_level (o_level),
    .o_full  (full),
    .o_empty (empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cx      <= '0;
      cy      <= '0;
      win_vld <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      end_q <= 1'b0;
      if (i_start) begin
        end_q   <= (state == S_WORK);
        state   <= S_FILL;
        cnt     <= '0;
        cx      <= '0;
        cy      <= '0;
        win_vld <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_FILL: begin
            if (cnt == FILL_END) begin
              state   <= S_WORK;
              win_vld <= 1'b1;
              cx      <= '0;
              cy      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_WORK: begin
            if (frame_last) begin
              state   <= S_IDLE;
              win_vld <= 1'b0;
              end_q   <= 1'b1;
              cx      <= '0;
              cy      <= '0;
            end else if (cx == CX_LAST) begin
              cx <= '0;
              cy <= cy + 1'b1;
            end else begin
              cx <= cx + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef BRIEF_DROP_CNT_EN
  logic drop_evt;
  always_comb drop_evt = (head_ok && (key_h < key_c)) || (i_flag && full && !pop && !flush);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_start)                   o_drop_cnt <= '0;
    else if (drop_evt && o_drop_cnt != '1)  o_drop_cnt <= o_drop_cnt + 1'b1;
  end
`endif

  always_comb begin
    o_start   = i_start && !i_rst;
    o_end     = end_q;
    o_win_vld = win_vld;
    o_cx      = cx;
    o_cy      = cy;
    o_full    = full;
    o_hit     = hit;
    o_kp_x    = hit ? head[KP_X_LSB +: COOR_W]      : '0;
    o_kp_y    = hit ? head[KP_Y_LSB +: COOR_W]      : '0;
    o_sin     = hit ? head[KP_SIN_LSB +: TRIG_W]    : '0;
    o_cos     = hit ? head[KP_COS_LSB +: TRIG_W]    : '0;
    o_score   = hit ? head[KP_SCORE_LSB +: SCORE_W] : '0;
  end

endmodule

// File: tb/tb_brief_kp_scheduler.sv
// Directed bench for brief_kp_scheduler with an 8x4 frame, FILL_LAT=20, DEPTH=4.
module tb_brief_kp_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_flag;
  logic [9:0]  i_coor_x, i_coor_y;
  logic [11:0] i_sin, i_cos;
  logic [7:0]  i_score;
  logic        o_start, o_end, o_win_vld, o_hit, o_full;
  logic [9:0]  o_cx, o_cy, o_kp_x, o_kp_y;
  logic [11:0] o_sin, o_cos;
  logic [7:0]  o_score;
  logic [2:0]  o_level;
`ifdef BRIEF_DROP_CNT_EN
  logic [15:0] o_drop_cnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int          hits;

  always #5 i_clk = ~i_clk;

  brief_kp_scheduler #(.WIDTH(8), .HEIGHT(4), .FILL_LAT(20), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_flag(i_flag),
    .i_coor_x(i_coor_x), .i_coor_y(i_coor_y), .i_sin(i_sin), .i_cos(i_cos),
    .i_score(i_score), .o_start(o_start), .o_end(o_end), .o_win_vld(o_win_vld),
    .o_cx(o_cx), .o_cy(o_cy), .o_hit(o_hit), .o_kp_x(o_kp_x), .o_kp_y(o_kp_y),
    .o_sin(o_sin), .o_cos(o_cos), .o_score(o_score), .o_level(o_level),
    .o_full(o_full)
`ifdef BRIEF_DROP_CNT_EN
    , .o_drop_cnt(o_drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_kp(input int x, input int y, input logic [11:0] s,
                          input logic [11:0] c, input logic [7:0] sc);
    i_flag   = 1'b1;
    i_coor_x = 10'(x);
    i_coor_y = 10'(y);
    i_sin    = s;
    i_cos    = c;
    i_score  = sc;
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_flag = 1'b0;
    i_coor_x = '0; i_coor_y = '0; i_sin = '0; i_cos = '0; i_score = '0;
    step; step;
    i_rst = 1'b0;
    #1;
    check("rst_win_vld", o_win_vld, 0);
    check("rst_level",   o_level,   0);
    check("rst_full",    o_full,    0);
    check("rst_end",     o_end,     0);
    check("rst_cxcy",    {o_cx, o_cy}, 0);
    step;

    // frame 1: single keypoint hit at (3,1)
    hits = 0;
    for (int c = 0; c <= 53; c++) begin
      i_start = (c == 0);
      i_flag  = 1'b0;
      if (c == 2) drive_kp(3, 1, 12'h123, 12'hABC, 8'h5A);
      #1;
      if (o_hit) hits++;
      case (c)
        0:  check("f1_start",     o_start, 1);
        1:  check("f1_start_one", o_start, 0);
        3:  check("f1_lvl_push",  o_level, 1);
        19: check("f1_vld_early", o_win_vld, 0);
        20: begin
          check("f1_vld_rise", o_win_vld, 1);
          check("f1_cx0", o_cx, 0);
          check("f1_cy0", o_cy, 0);
        end
        31: begin
          check("f1_hit",   o_hit, 1);
          check("f1_cx",    o_cx, 3);
          check("f1_cy",    o_cy, 1);
          check("f1_kp_x",  o_kp_x, 3);
          check("f1_kp_y",  o_kp_y, 1);
          check("f1_sin",   o_sin, 12'h123);
          check("f1_cos",   o_cos, 12'hABC);
          check("f1_score", o_score, 8'h5A);
          check("f1_lvl1",  o_level, 1);
        end
        32: check("f1_lvl0", o_level, 0);
        51: begin
          check("f1_end_early", o_end, 0);
          check("f1_last_xy",   {o_cx, o_cy}, {10'd7, 10'd3});
        end
        52: begin
          check("f1_end",     o_end, 1);
          check("f1_vld_off", o_win_vld, 0);
        end
        53: check("f1_end_one", o_end, 0);
        default: ;
      endcase
      step;
    end
    check("f1_hits", hits, 1);

    // frame 2: stale pop, full FIFO with drop, hit+push while full
    hits = 0;
    for (int c = 0; c <= 52; c++) begin
      i_start = (c == 0);
      i_flag  = 1'b0;
      if (c == 25) drive_kp(2, 0, 12'h001, 12'h002, 8'h03);
      if (c >= 30 && c <= 34) drive_kp(c - 30, 3, 12'h010, 12'h020, 8'(c));
      if (c == 44) drive_kp(5, 3, 12'h555, 12'h666, 8'h77);
      #1;
      if (o_hit) hits++;
      case (c)
        26: begin
          check("f2_stale_lvl", o_level, 1);
          check("f2_stale_hit", o_hit, 0);
        end
        27: begin
          check("f2_stale_gone", o_level, 0);
`ifdef BRIEF_DROP_CNT_EN
          check("f2_drop_stale", o_drop_cnt, 1);
`endif
        end
        34: check("f2_full_at_5th", o_full, 1);
        35: begin
          check("f2_full",  o_full, 1);
          check("f2_lvl4",  o_level, 4);
        end
        36: begin
`ifdef BRIEF_DROP_CNT_EN
          check("f2_drop_full", o_drop_cnt, 2);
`endif
        end
        44: begin
          check("f2_fullhit",   o_hit, 1);
          check("f2_fullhit_x", o_kp_x, 0);
          check("f2_fullhit_y", o_kp_y, 3);
          check("f2_fullhit_f", o_full, 1);
        end
        45: begin
          check("f2_lvl_keep", o_level, 4);
          check("f2_hit_x1",   o_kp_x, 1);
`ifdef BRIEF_DROP_CNT_EN
          check("f2_drop_keep", o_drop_cnt, 2);
`endif
        end
        47: check("f2_hit_x3", o_kp_x, 3);
        48: check("f2_hold",   o_hit, 0);
        49: begin
          check("f2_hit_x5",  o_kp_x, 5);
          check("f2_hit_sin", o_sin, 12'h555);
        end
        default: ;
      endcase
      step;
    end
    check("f2_hits", hits, 5);

    // frame 3: restart at centre (4,2) with two queued keypoints
    for (int c = 0; c <= 40; c++) begin
      i_start = (c == 0) || (c == 40);
      i_flag  = 1'b0;
      if (c == 10) drive_kp(0, 3, 12'h0, 12'h0, 8'h0);
      if (c == 11) drive_kp(1, 3, 12'h0, 12'h0, 8'h0);
      if (c == 40) drive_kp(7, 0, 12'hFED, 12'h321, 8'hC3);
      #1;
      case (c)
        1: begin
`ifdef BRIEF_DROP_CNT_EN
          check("f3_drop_clr", o_drop_cnt, 0);
`endif
        end
        40: begin
          check("f3_lvl2",    o_level, 2);
          check("f3_at_42",   {o_cx, o_cy}, {10'd4, 10'd2});
          check("f3_restart", o_start, 1);
        end
        default: ;
      endcase
      step;
    end

    // continuation after restart; c counts from the restart cycle
    for (int c = 1; c <= 28; c++) begin
      i_start = 1'b0;
      i_flag  = 1'b0;
      #1;
      case (c)
        1: begin
          check("r_end",      o_end, 1);
          check("r_start0",   o_start, 0);
          check("r_flush_lv", o_level, 1);
          check("r_vld_off",  o_win_vld, 0);
        end
        2:  check("r_end_one", o_end, 0);
        19: check("r_vld_early", o_win_vld, 0);
        20: check("r_vld_rise", o_win_vld, 1);
        27: begin
          check("r_hit",    o_hit, 1);
          check("r_hit_xy", {o_kp_x, o_kp_y}, {10'd7, 10'd0});
          check("r_score",  o_score, 8'hC3);
        end
        28: check("r_lvl0", o_level, 0);
        default: ;
      endcase
      step;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
